stash_to_dram: RTL

//  Write-back formatter; the mirror of the DRAM-to-stash unpacker. Takes Z blocks per bucket from
//  the stash eviction stream as {Leaf,PAddr,Real,Data} and emits DRAM bucket format:

---
 rtl/stash_to_dram.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/stash_to_dram.sv
// stash_to_dram: collects one bucket of stash eviction beats into a local
// buffer, then re-emits it in DRAM bucket format: HdrChunks header chunks
// carrying the packed {L, U, V} metadata, followed by the buffered payload.
module stash_to_dram #(
  parameter int BEDWidth    = 64,
  parameter int ORAMU       = 32,
  parameter int ORAML       = 32,
  parameter int ORAMZ       = 4,
  parameter int BlkChunks   = 8,
  parameter int HdrChunks   = 5,
  parameter int BktsPerPath = 33
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [BEDWidth-1:0] StashData,
  input  logic [ORAMU-1:0]    StashPAddr,
  input  logic [ORAML-1:0]    StashLeaf,
  input  logic                StashReal,
  input  logic                StashValid,
  output logic                StashReady,
  output logic [BEDWidth-1:0] DRAMData,
  output logic                DRAMValid,
  input  logic                DRAMReady,
  output logic                PathDone
);

  localparam int MaxChunks = (BlkChunks > HdrChunks) ? BlkChunks : HdrChunks;
  localparam int SW        = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
  localparam int CW        = (MaxChunks > 1) ? $clog2(MaxChunks) : 1;
  localparam int BW        = (BktsPerPath > 1) ? $clog2(BktsPerPath) : 1;
  localparam int Depth     = ORAMZ * BlkChunks;
  localparam int IW        = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int HdrBits   = HdrChunks * BEDWidth;

  typedef enum logic [1:0] {FILL = 2'd0, HDR = 2'd1, PAY = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [CW-1:0]       chunk_q, chunk_d;
  logic [BW-1:0]       bkt_q, bkt_d;
  logic [ORAMZ-1:0]    v_q, v_d;
  logic [ORAMU-1:0]    u_q [ORAMZ];
  logic [ORAMU-1:0]    u_d [ORAMZ];
  logic [ORAML-1:0]    l_q [ORAMZ];
  logic [ORAML-1:0]    l_d [ORAMZ];
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [BEDWidth-1:0] data_q, data_d;
  logic [BEDWidth-1:0] mem_q [Depth];
  logic [HdrBits-1:0]  hdr_s;
  logic [BEDWidth-1:0] hdr_chunk_s [HdrChunks];
  logic                stash_acc_s, dram_acc_s;
  logic                slot_last_s, blk_last_s, hdr_last_s, bkt_last_s;
  logic [IW-1:0]       idx_s, nxt_idx_s;

  // StashReady is forced low during reset; it never looks at StashValid.
  assign StashReady  = ready_q & ~Reset;
  assign DRAMValid   = valid_q;
  assign DRAMData    = data_q;
  assign stash_acc_s = StashValid & StashReady;
  assign dram_acc_s  = valid_q & DRAMReady;
  assign slot_last_s = (slot_q == SW'(ORAMZ - 1));
  assign blk_last_s  = (chunk_q == CW'(BlkChunks - 1));
  assign hdr_last_s  = (chunk_q == CW'(HdrChunks - 1));
  assign bkt_last_s  = (bkt_q == BW'(BktsPerPath - 1));
  assign idx_s       = IW'(int'(slot_q) * BlkChunks + int'(chunk_q));
  assign nxt_idx_s   = idx_s + IW'(1);
  // Pulses only in the cycle the final payload chunk of the last bucket is taken.
  assign PathDone    = dram_acc_s & (state_q == PAY) & slot_last_s & blk_last_s & bkt_last_s;

  // Latch per-slot metadata on a block's first beat; dummy blocks carry zero U/L.
  always_comb begin
    v_d = v_q;
    u_d = u_q;
    l_d = l_q;
    if (stash_acc_s && (chunk_q == '0)) begin
      v_d[slot_q] = StashReal;
      u_d[slot_q] = StashReal ? StashPAddr : '0;
      l_d[slot_q] = StashReal ? StashLeaf  : '0;
    end else begin
      v_d = v_q;
    end
  end

  // Pack the bucket header {pad, L[Z-1..0], U[Z-1..0], V} and split it into chunks.
  always_comb begin
    hdr_s = '0;
    hdr_s[ORAMZ-1:0] = v_d;
    for (int i = 0; i < ORAMZ; i++) begin
      hdr_s[ORAMZ + i*ORAMU +: ORAMU]               = u_d[i];
      hdr_s[ORAMZ*(1 + ORAMU) + i*ORAML +: ORAML]   = l_d[i];
    end
    for (int k = 0; k < HdrChunks; k++) begin
      hdr_chunk_s[k] = hdr_s[k*BEDWidth +: BEDWidth];
    end
  end

  // Next-state logic: fill the buffer, then emit header chunks, then payload.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    chunk_d = chunk_q;
    bkt_d   = bkt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      FILL: begin
        if (stash_acc_s) begin
          if (blk_last_s) begin
            chunk_d = '0;
            if (slot_last_s) begin
              slot_d  = '0;
              state_d = HDR;
              ready_d = 1'b0;
              valid_d = 1'b1;
              data_d  = hdr_chunk_s[0];
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end else begin
          state_d = FILL;
        end
      end
      HDR: begin
        if (dram_acc_s) begin
          if (hdr_last_s) begin
            chunk_d = '0;
            slot_d  = '0;
            state_d = PAY;
            data_d  = mem_q[0];
          end else begin
            chunk_d = chunk_q + 1'b1;
            data_d  = hdr_chunk_s[chunk_q + 1'b1];
          end
        end else begin
          state_d = HDR;
        end
      end
      PAY: begin
        if (dram_acc_s) begin
          if (blk_last_s) begin
            chunk_d = '0;
            if (slot_last_s) begin
              slot_d  = '0;
              state_d = FILL;
              valid_d = 1'b0;
              ready_d = 1'b1;
              bkt_d   = bkt_last_s ? '0 : bkt_q + 1'b1;
            end else begin
              slot_d = slot_q + 1'b1;
              data_d = mem_q[nxt_idx_s];
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
            data_d  = mem_q[nxt_idx_s];
          end
        end else begin
          state_d = PAY;
        end
      end
      default: begin
        state_d = FILL;
        slot_d  = '0;
        chunk_d = '0;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, counters, metadata and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FILL;
      slot_q  <= '0;
      chunk_q <= '0;
      bkt_q   <= '0;
      v_q     <= '0;
      for (int i = 0; i < ORAMZ; i++) begin
        u_q[i] <= '0;
        l_q[i] <= '0;
      end
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      chunk_q <= chunk_d;
      bkt_q   <= bkt_d;
      v_q     <= v_d;
      u_q     <= u_d;
      l_q     <= l_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Bucket payload buffer, written one accepted stash beat at a time.
  always_ff @(posedge Clock) begin
    if (stash_acc_s) begin
      mem_q[idx_s] <= StashData;
    end
  end

endmodule
